// File: rtl/lsu_if.sv
// Request / response / RAM strobe bundle between the execute stage,
// the load/store unit and the data RAM.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// The sender holds valid and its payload until that edge and never drops
// valid without ready; the receiver may change ready at any time.
interface lsu_if;
  // Request from the execute stage.
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [11:0] req_offset;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  // Response to writeback.
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_fault;
  logic [1:0]  resp_cause;
  logic [31:0] resp_addr;
  // Data RAM strobes.
  logic        ram_load;
  logic        ram_store;
  logic [2:0]  ram_access;
  logic [31:0] ram_addr;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_out;

  // The load/store unit side.
  modport slave (
    input  req_valid, req_load, req_store, req_funct3, req_base, req_offset,
           req_wdata, req_rd, resp_ready, ram_data_out,
    output req_ready, resp_valid, resp_rdata, resp_rd, resp_fault, resp_cause,
           resp_addr, ram_load, ram_store, ram_access, ram_addr, ram_data_in
  );

  // The surrounding pipeline / RAM side.
  modport master (
    output req_valid, req_load, req_store, req_funct3, req_base, req_offset,
           req_wdata, req_rd, resp_ready, ram_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_rd, resp_fault, resp_cause,
           resp_addr, ram_load, ram_store, ram_access, ram_addr, ram_data_in
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one request at a time, effective-address generation,
// funct3 legality and alignment checks, RAM strobe sequencing and a held
// valid/ready response register toward writeback.
module lsu #(
  parameter int RD_LAT = 0,   // extra ACCESS cycles before load data is sampled
  parameter int AW     = 32   // address/data width, fixed at 32
) (
  input  logic       clk,
  input  logic       rst,          // asynchronous, active-low
  lsu_if.slave       bus,
  output logic [1:0] dbg_state_o   // current FSM state for observation
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int CW = 8;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            ram_load_q;
  logic            ram_store_q;
  logic [2:0]      ram_access_q;
  logic [AW-1:0]   ram_addr_q;
  logic [AW-1:0]   ram_data_in_q;
  logic            resp_valid_q;
  logic [AW-1:0]   resp_rdata_q;
  logic [4:0]      resp_rd_q;
  logic            resp_fault_q;
  logic [1:0]      resp_cause_q;
  logic [AW-1:0]   resp_addr_q;

  logic [AW-1:0]   ea;
  logic            load_f3_ok;
  logic            store_f3_ok;
  logic            illegal;
  logic            misaligned;
  logic            fault;
  logic [1:0]      cause;
  logic            req_ready;
  logic            accept;

  // Decode of the live request: effective address, legality, alignment.
  always_comb begin
    ea          = bus.req_base + {{(AW-12){bus.req_offset[11]}}, bus.req_offset};
    load_f3_ok  = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                  (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                  (bus.req_funct3 == 3'b101);
    store_f3_ok = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                  (bus.req_funct3 == 3'b010);
    illegal     = (bus.req_load == bus.req_store) ||
                  (bus.req_load && !load_f3_ok) ||
                  (bus.req_store && !store_f3_ok);
    // funct3[1:0] selects the size for both loads and stores once legal.
    misaligned  = ((bus.req_funct3[1:0] == 2'b01) && ea[0]) ||
                  ((bus.req_funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
    fault       = illegal || misaligned;
    if (illegal)           cause = 2'b11;
    else if (bus.req_load) cause = 2'b01;
    else                   cause = 2'b10;
  end

  // A new request can enter when idle, or when the held response leaves now.
  assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.resp_ready);
  assign accept    = bus.req_valid && req_ready;

  // Main FSM; every output is a register so reset clears the strobes at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      ram_load_q    <= 1'b0;
      ram_store_q   <= 1'b0;
      ram_access_q  <= '0;
      ram_addr_q    <= '0;
      ram_data_in_q <= '0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_rd_q     <= '0;
      resp_fault_q  <= 1'b0;
      resp_cause_q  <= '0;
      resp_addr_q   <= '0;
    end else begin
      case (state_q)
        ST_ACCESS: begin
          if (ram_store_q) begin
            // The RAM writes on this edge; the store pulse is one cycle.
            ram_store_q  <= 1'b0;
            resp_rdata_q <= '0;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else if (cnt_q == CW'(RD_LAT)) begin
            ram_load_q   <= 1'b0;
            resp_rdata_q <= bus.ram_data_out;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          // IDLE or RESP: retire a consumed response, then maybe accept.
          if ((state_q == ST_RESP) && bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
          if (accept) begin
            resp_rd_q   <= bus.req_rd;
            resp_addr_q <= ea;
            if (fault) begin
              // Faults skip the RAM entirely and respond next cycle.
              resp_fault_q <= 1'b1;
              resp_cause_q <= cause;
              resp_rdata_q <= '0;
              resp_valid_q <= 1'b1;
              state_q      <= ST_RESP;
            end else begin
              resp_fault_q  <= 1'b0;
              resp_cause_q  <= 2'b00;
              resp_valid_q  <= 1'b0;
              ram_addr_q    <= ea;
              ram_access_q  <= bus.req_funct3;
              ram_data_in_q <= bus.req_wdata;
              ram_load_q    <= bus.req_load;
              ram_store_q   <= bus.req_store;
              cnt_q         <= '0;
              state_q       <= ST_ACCESS;
            end
          end
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.resp_rd     = resp_rd_q;
  assign bus.resp_fault  = resp_fault_q;
  assign bus.resp_cause  = resp_cause_q;
  assign bus.resp_addr   = resp_addr_q;
  assign bus.ram_load    = ram_load_q;
  assign bus.ram_store   = ram_store_q;
  assign bus.ram_access  = ram_access_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_data_in = ram_data_in_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: two instances (RD_LAT=0 and RD_LAT=2) sharing one
// byte-addressed RAM model; a select flag routes requests to one of them.
module tb_lsu;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared stimulus.
  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_load = 1'b0, req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_base = '0, req_wdata = '0;
  logic [11:0] req_offset = '0;
  logic [4:0]  req_rd = '0;
  logic        resp_ready = 1'b1;
  logic [1:0]  dbg0, dbg2;

  lsu_if if0();
  lsu_if if2();

  lsu #(.RD_LAT(0)) u_lsu0 (.clk(clk), .rst(rst), .bus(if0.slave), .dbg_state_o(dbg0));
  lsu #(.RD_LAT(2)) u_lsu2 (.clk(clk), .rst(rst), .bus(if2.slave), .dbg_state_o(dbg2));

  assign if0.req_valid = req_valid & ~sel;
  assign if2.req_valid = req_valid & sel;
  assign if0.req_load = req_load;      assign if2.req_load = req_load;
  assign if0.req_store = req_store;    assign if2.req_store = req_store;
  assign if0.req_funct3 = req_funct3;  assign if2.req_funct3 = req_funct3;
  assign if0.req_base = req_base;      assign if2.req_base = req_base;
  assign if0.req_offset = req_offset;  assign if2.req_offset = req_offset;
  assign if0.req_wdata = req_wdata;    assign if2.req_wdata = req_wdata;
  assign if0.req_rd = req_rd;          assign if2.req_rd = req_rd;
  assign if0.resp_ready = resp_ready;  assign if2.resp_ready = resp_ready;

  // Selected-instance view.
  logic        req_ready_m, resp_valid_m, ram_load_m, ram_store_m;
  logic [2:0]  ram_access_m;
  logic [31:0] ram_addr_m;
  logic [71:0] resp_act;
  assign req_ready_m  = sel ? if2.req_ready  : if0.req_ready;
  assign resp_valid_m = sel ? if2.resp_valid : if0.resp_valid;
  assign ram_load_m   = sel ? if2.ram_load   : if0.ram_load;
  assign ram_store_m  = sel ? if2.ram_store  : if0.ram_store;
  assign ram_access_m = sel ? if2.ram_access : if0.ram_access;
  assign ram_addr_m   = sel ? if2.ram_addr   : if0.ram_addr;
  assign resp_act = sel ? {if2.resp_rd, if2.resp_fault, if2.resp_cause, if2.resp_addr, if2.resp_rdata}
                        : {if0.resp_rd, if0.resp_fault, if0.resp_cause, if0.resp_addr, if0.resp_rdata};

  // RAM model: little-endian bytes, extension done on read.
  logic [7:0] mem [0:255];

  function automatic logic [31:0] ram_rd(input logic [31:0] a, input logic [2:0] acc);
    logic [7:0] i, b0, b1, b2, b3;
    i  = a[7:0];
    b0 = mem[i];
    b1 = mem[i + 8'd1];
    b2 = mem[i + 8'd2];
    b3 = mem[i + 8'd3];
    case (acc)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b010:  return {b3, b2, b1, b0};
      3'b100:  return {24'h0, b0};
      3'b101:  return {16'h0, b1, b0};
      default: return 32'h0;
    endcase
  endfunction

  always_comb if0.ram_data_out = ram_rd(if0.ram_addr, if0.ram_access);
  always_comb if2.ram_data_out = ram_rd(if2.ram_addr, if2.ram_access);

  task automatic ram_wr(input logic [31:0] a, input logic [2:0] acc, input logic [31:0] d);
    logic [7:0] i;
    i = a[7:0];
    mem[i] = d[7:0];
    if (acc != 3'b000) mem[i + 8'd1] = d[15:8];
    if (acc == 3'b010) begin
      mem[i + 8'd2] = d[23:16];
      mem[i + 8'd3] = d[31:24];
    end
  endtask

  always @(posedge clk) begin
    if (if0.ram_store) ram_wr(if0.ram_addr, if0.ram_access, if0.ram_data_in);
    if (if2.ram_store) ram_wr(if2.ram_addr, if2.ram_access, if2.ram_data_in);
  end

  // Scoreboard state.
  int tests_run = 0;
  int fails = 0;
  logic [71:0] exp_q[$];
  int hs_q[$];
  logic [31:0] st_addr_q[$];
  int ld_hi = 0, st_hi = 0, acc_cyc = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: strobe counting and response scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (ram_load_m) ld_hi++;
      if (ram_store_m) begin
        st_hi++;
        st_addr_q.push_back(ram_addr_m);
        chk("store_access", 72'(ram_access_m), 72'(3'b010));
      end
      if (resp_valid_m && resp_ready) begin
        hs_q.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_resp", resp_act, 72'h0 ^ ~resp_act);
        else chk("resp", resp_act, exp_q.pop_front());
      end
    end
  end

  typedef struct {
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] base;
    logic [11:0] off;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        fault;
    logic [1:0]  cause;
    logic [31:0] addr;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] base, input logic [11:0] off,
                              input logic [31:0] wdata, input logic [4:0] rd,
                              input logic fault, input logic [1:0] cause,
                              input logic [31:0] addr, input logic [31:0] rdata);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.base = base; v.off = off; v.wdata = wdata;
    v.rd = rd; v.fault = fault; v.cause = cause; v.addr = addr; v.rdata = rdata;
    return v;
  endfunction

  task automatic send(input vec_t v);
    int n;
    logic ok;
    req_load = v.ld; req_store = v.st; req_funct3 = v.f3; req_base = v.base;
    req_offset = v.off; req_wdata = v.wdata; req_rd = v.rd; req_valid = 1'b1;
    exp_q.push_back({v.rd, v.fault, v.cause, v.addr, v.rdata});
    n = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = req_ready_m;
      if (ok) acc_cyc = cyc;
      @(posedge clk);
      n++;
    end
    #1;
    req_valid = 1'b0;
    if (!ok) begin
      void'(exp_q.pop_back());
      chk("send_timeout", 72'(n), 72'(0));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 72'(exp_q.size()), 72'(0));
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_resp0"}, {if0.resp_rd, if0.resp_fault, if0.resp_cause, if0.resp_addr, if0.resp_rdata}, 72'h0);
    chk({tag, "_strobes0"}, 72'({if0.resp_valid, if0.ram_load, if0.ram_store, if0.ram_access, dbg0}), 72'h0);
    chk({tag, "_ram0"}, 72'({if0.ram_addr, if0.ram_data_in}), 72'h0);
    chk({tag, "_all2"}, 72'({if2.resp_valid, if2.ram_load, if2.ram_store, if2.resp_fault, dbg2,
                             |if2.resp_rdata, |if2.resp_addr, |if2.ram_addr}), 72'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    //                  ld    st    f3      base          off      wdata         rd  flt  cause  addr          rdata
    vecs[0]  = mk(1'b0, 1'b1, 3'b010, 32'h0,        12'h000, 32'h00112233, 1,  0, 2'b00, 32'h0,        32'h0);
    vecs[1]  = mk(1'b0, 1'b1, 3'b010, 32'h8,        12'hFFC, 32'hAABBCCDD, 2,  0, 2'b00, 32'h4,        32'h0);
    vecs[2]  = mk(1'b1, 1'b0, 3'b000, 32'h4,        12'h003, 32'h0,        3,  0, 2'b00, 32'h7,        32'hFFFFFFAA);
    vecs[3]  = mk(1'b1, 1'b0, 3'b100, 32'h7,        12'h000, 32'h0,        4,  0, 2'b00, 32'h7,        32'h000000AA);
    vecs[4]  = mk(1'b1, 1'b0, 3'b001, 32'h2,        12'h000, 32'h0,        5,  0, 2'b00, 32'h2,        32'h00000011);
    vecs[5]  = mk(1'b1, 1'b0, 3'b010, 32'h4,        12'h000, 32'h0,        6,  0, 2'b00, 32'h4,        32'hAABBCCDD);
    vecs[6]  = mk(1'b1, 1'b0, 3'b010, 32'h2,        12'h000, 32'h0,        7,  1, 2'b01, 32'h2,        32'h0);
    vecs[7]  = mk(1'b0, 1'b1, 3'b001, 32'h5,        12'h000, 32'h0,        8,  1, 2'b10, 32'h5,        32'h0);
    vecs[8]  = mk(1'b1, 1'b0, 3'b011, 32'h0,        12'h000, 32'h0,        9,  1, 2'b11, 32'h0,        32'h0);
    vecs[9]  = mk(1'b1, 1'b1, 3'b010, 32'h10,       12'h000, 32'h0,        10, 1, 2'b11, 32'h10,       32'h0);
    vecs[10] = mk(1'b1, 1'b0, 3'b101, 32'hFFFFFFFE, 12'h008, 32'h0,        11, 0, 2'b00, 32'h6,        32'h0000AABB);
    vecs[11] = mk(1'b0, 1'b1, 3'b100, 32'h20,       12'h000, 32'h0,        12, 1, 2'b11, 32'h20,       32'h0);
    vecs[12] = mk(1'b0, 1'b0, 3'b010, 32'h24,       12'h000, 32'h0,        13, 1, 2'b11, 32'h24,       32'h0);

    // Reset state.
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Table on the RD_LAT=0 instance.
    st_hi = 0;
    st_addr_q.delete();
    for (int i = 0; i < 13; i++) send(vecs[i]);
    drain();
    chk("store_pulses", 72'(st_hi), 72'(2));
    chk("store_addrs", 72'({st_addr_q.size() > 0 ? st_addr_q[0] : 32'hFFFF, st_addr_q.size() > 1 ? st_addr_q[1] : 32'hFFFF}),
        72'({32'h0, 32'h4}));

    // Load strobe length, RD_LAT=0.
    ld_hi = 0;
    send(vecs[5]);
    drain();
    chk("ld_cycles_lat0", 72'(ld_hi), 72'(1));

    // Faulting load never touches the RAM.
    ld_hi = 0;
    send(vecs[6]);
    drain();
    chk("fault_no_load", 72'(ld_hi), 72'(0));

    // Four loads back-to-back: one response every 2 cycles.
    hs_q.delete();
    for (int i = 2; i < 6; i++) send(vecs[i]);
    drain();
    chk("b2b_count", 72'(hs_q.size()), 72'(4));
    for (int i = 1; i < hs_q.size(); i++) chk("b2b_gap", 72'(hs_q[i] - hs_q[i-1]), 72'(2));

    // Faults back-to-back: one per cycle.
    hs_q.delete();
    for (int i = 6; i < 10; i++) send(vecs[i]);
    drain();
    chk("fault_count", 72'(hs_q.size()), 72'(4));
    for (int i = 1; i < hs_q.size(); i++) chk("fault_gap", 72'(hs_q[i] - hs_q[i-1]), 72'(1));

    // Writeback stall: response held, no new request accepted.
    begin
      int n;
      resp_ready = 1'b0;
      send(mk(1'b1, 1'b0, 3'b010, 32'h4, 12'h000, 32'h0, 20, 0, 2'b00, 32'h4, 32'hAABBCCDD));
      n = 0;
      while (!resp_valid_m && n < 20) begin @(negedge clk); n++; end
      chk("stall_resp_seen", 72'(resp_valid_m), 72'(1));
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("stall_fields", resp_act, {5'd20, 1'b0, 2'b00, 32'h4, 32'hAABBCCDD});
        chk("stall_ready", 72'({resp_valid_m, req_ready_m}), 72'(2'b10));
      end
      @(posedge clk); #1;
      hs_q.delete();
      resp_ready = 1'b1;
      send(mk(1'b1, 1'b0, 3'b000, 32'h7, 12'h000, 32'h0, 21, 0, 2'b00, 32'h7, 32'hFFFFFFAA));
      chk("stall_same_cycle_accept", 72'(hs_q.size() > 0 ? hs_q[0] : -1), 72'(acc_cyc));
      drain();
    end

    // RD_LAT=2 instance: table loads plus a fault.
    sel = 1'b1;
    for (int i = 2; i < 7; i++) send(vecs[i]);
    send(vecs[10]);
    drain();
    ld_hi = 0;
    send(vecs[5]);
    drain();
    chk("ld_cycles_lat2", 72'(ld_hi), 72'(3));
    hs_q.delete();
    for (int i = 2; i < 5; i++) send(vecs[i]);
    drain();
    for (int i = 1; i < hs_q.size(); i++) chk("b2b_gap_lat2", 72'(hs_q[i] - hs_q[i-1]), 72'(4));
    sel = 1'b0;

    // Reset in the middle of a store's ACCESS cycle.
    send(mk(1'b0, 1'b1, 3'b010, 32'h0, 12'h000, 32'h12345678, 22, 0, 2'b00, 32'h0, 32'h0));
    chk("mid_store_strobe", 72'(if0.ram_store), 72'(1));
    #1 rst = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    send(mk(1'b1, 1'b0, 3'b010, 32'h0, 12'h000, 32'h0, 23, 0, 2'b00, 32'h0, 32'h00112233));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
Load/store unit that sits directly upstream of the data RAM. It accepts one memory request at a time from the execute stage and computes the effective address. It checks funct3 legality and alignment, then drives the RAM's load/store/access/addr/data_in strobes. It returns the load result, or the fault, to writeback through a valid/ready response register.

Parameters:
RD_LAT, 0, extra wait cycles after the first ACCESS cycle before RAM read data is sampled (0 = RAM read data valid in the same cycle).
AW, 32, address/data width; fixed at 32 in this design.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid&&req_ready at a clk edge
req_load  input  1  request is a load
req_store  input  1  request is a store
req_funct3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_base  input  32  base register value
req_offset  input  12  signed immediate
req_wdata  input  32  store data; low byte/half used for SB/SH
req_rd  input  5  destination register tag
resp_valid  output  1  response held until resp_ready
resp_ready  input  1  writeback accepts response
resp_rdata  output  32  load result (already sign/zero-extended by RAM); 0 for stores and faults
resp_rd  output  5  tag of the completed request
resp_fault  output  1  request faulted; no RAM access performed
resp_cause  output  2  01 misaligned load, 10 misaligned store, 11 illegal request
resp_addr  output  32  effective address (fault address when resp_fault)
ram_load  output  1  to RAM load
ram_store  output  1  to RAM store
ram_access  output  3  to RAM access (= registered funct3)
ram_addr  output  32  to RAM addr
ram_data_in  output  32  to RAM data_in
ram_data_out  input  32  from RAM data_out

Behaviour:
- States: IDLE, ACCESS, RESP. Reset (rst=0, asynchronous): state IDLE, all outputs 0, wait counter 0. ram_load/ram_store drop immediately on reset assertion, so no write can occur mid-reset.
- Effective address: ea = req_base + sext(req_offset), computed modulo 2^32 with wrap-around and no fault on overflow.
- Illegal (cause 11):
  - req_load==req_store;
  - a load with funct3 outside {000,001,010,100,101};
  - a store with funct3 outside {000,001,010}.
- Misaligned:
  - H/HU/SH with ea[0]=1;
  - W/SW with ea[1:0]!=0.
  - Illegal takes priority over misaligned.
- req_ready = (state==IDLE) || (state==RESP && resp_ready).
- On accept: latch ea, funct3, wdata, rd, and op.
  - If the request is legal, go to ACCESS.
  - If it faults, go straight to RESP with resp_fault=1, the matching cause, resp_addr=ea and resp_rdata=0. No RAM strobe is driven.
- ACCESS:
  - ram_addr, ram_access and ram_data_in hold the latched values.
  - A store asserts ram_store for exactly one cycle (the RAM writes on that edge), then goes to RESP with resp_rdata=0.
  - A load asserts ram_load for 1+RD_LAT cycles, with the counter counting up from 0. On the edge ending the last cycle, ram_data_out is captured into resp_rdata and the state goes to RESP.
- ram_load/ram_store are 0 in every state except ACCESS. ram_addr/ram_access/ram_data_in keep their last values outside ACCESS.
- RESP:
  - resp_valid=1.
  - resp_rdata, resp_rd, resp_fault, resp_cause and resp_addr are stable until the handshake.
  - On resp_ready, leave RESP. If a new request is accepted in the same cycle, take its next state (ACCESS or RESP-with-fault); otherwise go to IDLE.
  - Back-to-back throughput: legal stores 1 request / 2 cycles; legal loads 1 request / (2+RD_LAT) cycles; faulting requests 1 per cycle.
- resp_valid is 0 in IDLE and ACCESS. resp_valid never drops without resp_ready.
- req_* inputs are ignored when not accepted. The latched values, not live inputs, drive the RAM.
- Reset asserted in ACCESS or RESP drops the request and its response; no partial store is visible after that edge.

Test Plan:
- SW base=0 off=0 wdata=0x00112233, then SW base=8 off=-4 wdata=0xAABBCCDD -> ram_store pulses exactly one cycle each at ram_addr 0 and 4, ram_access=010; resp_fault=0, resp_rdata=0.
- After the stores above, LB at ea 7 -> resp_rdata=0xFFFFFFAA; LBU at ea 7 -> 0x000000AA; LH at ea 2 -> 0x00000011; LW at ea 4 -> 0xAABBCCDD. Check with RD_LAT=0 and RD_LAT=2; ram_load high for 1 and 3 cycles respectively.
- LW at ea 2 -> resp_fault=1, cause 01, resp_addr=2, ram_load never asserted. SH at ea 5 -> cause 10. Load with funct3=011 -> cause 11. Both req_load and req_store high -> cause 11.
- resp_ready held low 5 cycles during RESP -> response fields stable and req_ready=0. Then resp_ready=1 with req_valid=1 -> the new request is accepted in that cycle and no cycle is lost.
- Four loads back-to-back with resp_ready=1, RD_LAT=0 -> one response every 2 cycles, tags in order.
- rst driven low mid-ACCESS of an SW to addr 0 with wdata 0x12345678 -> ram_store goes to 0 immediately and all outputs are 0. A subsequent LW at addr 0 returns the prior contents.
